game_move_ctrl: RTL and testbench

GAME_MOVE_CTRL -- requirements
Module: game_move_ctrl

---
 rtl/game_move_ctrl_if.sv | 27 ++
 rtl/game_move_ctrl.sv | 111 +++++++++++
 tb/tb_game_move_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/game_move_ctrl_if.sv
// Move handshake, checker loop-back and game status bundle for game_move_ctrl.
// The slave side is the controller; the master side is the player/checker environment.
interface game_move_ctrl_if;
   logic       new_game;
   logic       move_valid;
   logic [3:0] move_idx;
   logic       move_ready;
   logic [8:0] check_array;
   logic       win_in;
   logic       tie_in;
   logic [8:0] board_x;
   logic [8:0] board_o;
   logic       turn;
   logic       game_over;
   logic [1:0] winner;
   logic       move_err;

   modport slave (
      input  new_game, move_valid, move_idx, win_in, tie_in,
      output move_ready, check_array, board_x, board_o, turn, game_over, winner, move_err
   );

   modport master (
      output new_game, move_valid, move_idx, win_in, tie_in,
      input  move_ready, check_array, board_x, board_o, turn, game_over, winner, move_err
   );
endinterface

// File: rtl/game_move_ctrl.sv
// Tic-tac-toe move controller: accepts moves, keeps both boards and consults an
// external win/tie checker one cycle after each legal move.
//
// state | meaning
// WAIT  | ready for a move from the player given by turn
// CHECK | one cycle: checker looks at the last mover's board
// DONE  | game finished, moves ignored until new_game
module game_move_ctrl #(
   parameter bit FIRST_PLAYER = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   game_move_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {
      WAIT  = 2'd0,
      CHECK = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t     state, state_nxt;
   logic [8:0] board_x, board_o;
   logic [3:0] move_count;
   logic       turn, last_mover, has_moved;
   logic       game_over, move_err;
   logic [1:0] winner;
   logic       move_ready;
   logic [8:0] check_array;
   logic [8:0] cell_mask;
   logic       accept, legal;

   // Out-of-range indices shift the one-hot out of the 9-bit mask entirely.
   assign cell_mask = 9'd1 << bus.move_idx;
   assign legal     = (bus.move_idx <= 4'd8) && (((board_x | board_o) & cell_mask) == 9'd0);
   assign accept    = bus.move_valid && move_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= WAIT;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (bus.new_game) begin
         state_nxt = WAIT;
      end else begin
         case (state)
            WAIT:    if (accept && legal) state_nxt = CHECK;
            CHECK:   if (bus.win_in || bus.tie_in || move_count == 4'd9) state_nxt = DONE;
                     else state_nxt = WAIT;
            DONE:    state_nxt = DONE;
            default: state_nxt = WAIT;
         endcase
      end
   end

   // move_ready is forced low while reset is held, not just by the WAIT state.
   always_comb begin
      move_ready  = rst_n && (state == WAIT) && !bus.new_game;
      check_array = 9'd0;
      if (has_moved) check_array = last_mover ? board_o : board_x;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         board_x    <= 9'd0;
         board_o    <= 9'd0;
         move_count <= 4'd0;
         turn       <= FIRST_PLAYER;
         last_mover <= 1'b0;
         has_moved  <= 1'b0;
         winner     <= 2'b00;
         game_over  <= 1'b0;
         move_err   <= 1'b0;
      end else if (bus.new_game) begin
         board_x    <= 9'd0;
         board_o    <= 9'd0;
         move_count <= 4'd0;
         turn       <= FIRST_PLAYER;
         last_mover <= 1'b0;
         has_moved  <= 1'b0;
         winner     <= 2'b00;
         game_over  <= 1'b0;
         move_err   <= 1'b0;
      end else begin
         move_err  <= accept && !legal;
         game_over <= (state_nxt == DONE);
         if (accept && legal) begin
            if (turn) board_o <= board_o | cell_mask;
            else      board_x <= board_x | cell_mask;
            last_mover <= turn;
            has_moved  <= 1'b1;
            move_count <= move_count + 4'd1;
         end
         if (state == CHECK) begin
            if (bus.win_in)                              winner <= last_mover ? 2'b10 : 2'b01;
            else if (bus.tie_in || move_count == 4'd9)   winner <= 2'b11;
            else                                         turn   <= ~turn;
         end
      end
   end

   assign bus.move_ready  = move_ready;
   assign bus.check_array = check_array;
   assign bus.board_x     = board_x;
   assign bus.board_o     = board_o;
   assign bus.turn        = turn;
   assign bus.game_over   = game_over;
   assign bus.winner      = winner;
   assign bus.move_err    = move_err;
endmodule

// File: tb/tb_game_move_ctrl.sv
// Directed bench for game_move_ctrl: move table with hand-computed board/result
// expectations, plus reset, DONE-lockout and reset-during-CHECK sequences.
module tb_game_move_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   game_move_ctrl_if bus ();

   game_move_ctrl #(.FIRST_PLAYER(1'b0)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // Downstream checker: any of the 8 lines complete, or exactly 5 marks.
   localparam logic [8:0] LINES [8] = '{9'h1C0, 9'h038, 9'h007, 9'h124,
                                        9'h092, 9'h049, 9'h111, 9'h054};
   always_comb begin
      bus.win_in = 1'b0;
      for (int i = 0; i < 8; i++)
         if ((bus.check_array & LINES[i]) == LINES[i]) bus.win_in = 1'b1;
      bus.tie_in = ($countones(bus.check_array) == 5);
   end

   typedef struct {
      bit         ng;
      logic [3:0] idx;
      bit         err;
      logic [8:0] x;
      logic [8:0] o;
      bit         t;
      logic [1:0] w;
      bit         over;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mv(bit ng, logic [3:0] idx, bit err, logic [8:0] x,
                               logic [8:0] o, bit t, logic [1:0] w, bit over);
      vec_t v;
      v.ng = ng; v.idx = idx; v.err = err; v.x = x; v.o = o;
      v.t = t; v.w = w; v.over = over;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic accept_move(input logic [3:0] idx);
      int waited = 0;
      @(negedge clk);
      while (!bus.move_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      chk("ready_before_move", 32'(bus.move_ready), 32'd1);
      bus.move_valid = 1'b1;
      bus.move_idx   = idx;
      @(posedge clk);
      #1 bus.move_valid = 1'b0;
   endtask

   task automatic check_state(input int row, input vec_t v);
      chk($sformatf("row%0d_board_x", row), 32'(bus.board_x), 32'(v.x));
      chk($sformatf("row%0d_board_o", row), 32'(bus.board_o), 32'(v.o));
      chk($sformatf("row%0d_turn", row), 32'(bus.turn), 32'(v.t));
      chk($sformatf("row%0d_winner", row), 32'(bus.winner), 32'(v.w));
      chk($sformatf("row%0d_game_over", row), 32'(bus.game_over), 32'(v.over));
      chk($sformatf("row%0d_move_ready", row), 32'(bus.move_ready), 32'(!v.over));
   endtask

   task automatic run_vec(input int row, input vec_t v);
      if (v.ng) begin
         @(negedge clk);
         bus.new_game   = 1'b1;
         bus.move_valid = 1'b1;
         bus.move_idx   = v.idx;
         #1 chk($sformatf("row%0d_ready_during_ng", row), 32'(bus.move_ready), 32'd0);
         @(negedge clk);
         bus.new_game   = 1'b0;
         bus.move_valid = 1'b0;
         chk($sformatf("row%0d_err_after_ng", row), 32'(bus.move_err), 32'd0);
         @(negedge clk);
         check_state(row, v);
      end else begin
         accept_move(v.idx);
         @(negedge clk);
         chk($sformatf("row%0d_move_err", row), 32'(bus.move_err), 32'(v.err));
         @(negedge clk);
         chk($sformatf("row%0d_err_cleared", row), 32'(bus.move_err), 32'd0);
         check_state(row, v);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n          = 1'b0;
      bus.new_game   = 1'b0;
      bus.move_valid = 1'b0;
      bus.move_idx   = 4'd0;

      // ng idx err x o turn winner over
      vecs.push_back(mv(1, 4'd0, 0, 9'h000, 9'h000, 0, 2'b00, 0));
      vecs.push_back(mv(0, 4'd9, 1, 9'h000, 9'h000, 0, 2'b00, 0));
      vecs.push_back(mv(0, 4'd4, 0, 9'h010, 9'h000, 1, 2'b00, 0));
      vecs.push_back(mv(0, 4'd4, 1, 9'h010, 9'h000, 1, 2'b00, 0));
      vecs.push_back(mv(1, 4'd5, 0, 9'h000, 9'h000, 0, 2'b00, 0));
      // X wins on the 8-5-2 column
      vecs.push_back(mv(0, 4'd8, 0, 9'h100, 9'h000, 1, 2'b00, 0));
      vecs.push_back(mv(0, 4'd0, 0, 9'h100, 9'h001, 0, 2'b00, 0));
      vecs.push_back(mv(0, 4'd5, 0, 9'h120, 9'h001, 1, 2'b00, 0));
      vecs.push_back(mv(0, 4'd1, 0, 9'h120, 9'h003, 0, 2'b00, 0));
      vecs.push_back(mv(0, 4'd2, 0, 9'h124, 9'h003, 0, 2'b01, 1));
      // Full-board tie
      vecs.push_back(mv(1, 4'd0, 0, 9'h000, 9'h000, 0, 2'b00, 0));
      vecs.push_back(mv(0, 4'd8, 0, 9'h100, 9'h000, 1, 2'b00, 0));
      vecs.push_back(mv(0, 4'd7, 0, 9'h100, 9'h080, 0, 2'b00, 0));
      vecs.push_back(mv(0, 4'd6, 0, 9'h140, 9'h080, 1, 2'b00, 0));
      vecs.push_back(mv(0, 4'd4, 0, 9'h140, 9'h090, 0, 2'b00, 0));
      vecs.push_back(mv(0, 4'd5, 0, 9'h160, 9'h090, 1, 2'b00, 0));
      vecs.push_back(mv(0, 4'd3, 0, 9'h160, 9'h098, 0, 2'b00, 0));
      vecs.push_back(mv(0, 4'd1, 0, 9'h162, 9'h098, 1, 2'b00, 0));
      vecs.push_back(mv(0, 4'd2, 0, 9'h162, 9'h09C, 0, 2'b00, 0));
      vecs.push_back(mv(0, 4'd0, 0, 9'h163, 9'h09C, 0, 2'b11, 1));
      // O wins on the middle row
      vecs.push_back(mv(1, 4'd0, 0, 9'h000, 9'h000, 0, 2'b00, 0));
      vecs.push_back(mv(0, 4'd0, 0, 9'h001, 9'h000, 1, 2'b00, 0));
      vecs.push_back(mv(0, 4'd4, 0, 9'h001, 9'h010, 0, 2'b00, 0));
      vecs.push_back(mv(0, 4'd1, 0, 9'h003, 9'h010, 1, 2'b00, 0));
      vecs.push_back(mv(0, 4'd3, 0, 9'h003, 9'h018, 0, 2'b00, 0));
      vecs.push_back(mv(0, 4'd8, 0, 9'h103, 9'h018, 1, 2'b00, 0));
      vecs.push_back(mv(0, 4'd5, 0, 9'h103, 9'h038, 1, 2'b10, 1));

      #12;
      chk("rst_board_x", 32'(bus.board_x), 32'h0);
      chk("rst_board_o", 32'(bus.board_o), 32'h0);
      chk("rst_turn", 32'(bus.turn), 32'd0);
      chk("rst_winner", 32'(bus.winner), 32'd0);
      chk("rst_game_over", 32'(bus.game_over), 32'd0);
      chk("rst_move_err", 32'(bus.move_err), 32'd0);
      chk("rst_move_ready", 32'(bus.move_ready), 32'd0);
      chk("rst_check_array", 32'(bus.check_array), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("ready_after_rst", 32'(bus.move_ready), 32'd1);

      foreach (vecs[i]) run_vec(i, vecs[i]);

      // DONE must ignore further move requests.
      @(negedge clk);
      bus.move_valid = 1'b1;
      bus.move_idx   = 4'd2;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("done_ready", 32'(bus.move_ready), 32'd0);
         chk("done_board_x", 32'(bus.board_x), 32'h103);
         chk("done_board_o", 32'(bus.board_o), 32'h038);
         chk("done_err", 32'(bus.move_err), 32'd0);
         chk("done_over", 32'(bus.game_over), 32'd1);
      end
      bus.move_valid = 1'b0;

      // Reset while the winning move X2 is under evaluation.
      run_vec(100, mv(1, 4'd0, 0, 9'h000, 9'h000, 0, 2'b00, 0));
      run_vec(101, mv(0, 4'd0, 0, 9'h001, 9'h000, 1, 2'b00, 0));
      run_vec(102, mv(0, 4'd4, 0, 9'h001, 9'h010, 0, 2'b00, 0));
      run_vec(103, mv(0, 4'd1, 0, 9'h003, 9'h010, 1, 2'b00, 0));
      run_vec(104, mv(0, 4'd3, 0, 9'h003, 9'h018, 0, 2'b00, 0));
      accept_move(4'd2);
      chk("pre_rst_board_x", 32'(bus.board_x), 32'h007);
      #1 rst_n = 1'b0;
      #1;
      chk("midchk_board_x", 32'(bus.board_x), 32'h0);
      chk("midchk_board_o", 32'(bus.board_o), 32'h0);
      chk("midchk_turn", 32'(bus.turn), 32'd0);
      chk("midchk_winner", 32'(bus.winner), 32'd0);
      chk("midchk_game_over", 32'(bus.game_over), 32'd0);
      chk("midchk_move_err", 32'(bus.move_err), 32'd0);
      chk("midchk_move_ready", 32'(bus.move_ready), 32'd0);
      chk("midchk_check_array", 32'(bus.check_array), 32'h0);
      @(negedge clk);
      @(negedge clk);
      chk("midchk_winner_held", 32'(bus.winner), 32'd0);
      rst_n = 1'b1;
      #1 chk("midchk_ready_after", 32'(bus.move_ready), 32'd1);
      run_vec(105, mv(0, 4'd4, 0, 9'h010, 9'h000, 1, 2'b00, 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
